// File: rtl/mult_issue_if.sv
// Bundle of operand intake, mult handshake and response signals for mult_issue_ctrl.
interface mult_issue_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    // operand intake
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_arg_a;
    logic [15:0]      in_arg_b;
    logic             in_corrupt_a;
    logic             in_corrupt_b;

    // mult handshake
    logic             req;
    logic             ack;
    logic [15:0]      arg_a;
    logic [15:0]      arg_b;
    logic             arg_a_parity;
    logic             arg_b_parity;
    logic             result_rdy;
    logic [31:0]      result;
    logic             result_parity;
    logic             arg_parity_error;

    // response
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic             out_parity_ok;
    logic             out_arg_err;
    logic             out_timeout;
    logic [CNT_W-1:0] fifo_count;

    // environment side: producer, mult and response consumer
    modport master (
        output in_valid, in_arg_a, in_arg_b, in_corrupt_a, in_corrupt_b,
        output ack, result_rdy, result, result_parity, arg_parity_error,
        output out_ready,
        input  in_ready, req, arg_a, arg_b, arg_a_parity, arg_b_parity,
        input  out_valid, out_result, out_parity_ok, out_arg_err, out_timeout,
        input  fifo_count
    );

    // controller side
    modport slave (
        input  in_valid, in_arg_a, in_arg_b, in_corrupt_a, in_corrupt_b,
        input  ack, result_rdy, result, result_parity, arg_parity_error,
        input  out_ready,
        output in_ready, req, arg_a, arg_b, arg_a_parity, arg_b_parity,
        output out_valid, out_result, out_parity_ok, out_arg_err, out_timeout,
        output fifo_count
    );
endinterface

// File: rtl/mult_issue_ctrl.sv
// Issue stage for the parity-protected 16x16 multiplier: buffers operand pairs,
// generates (optionally corrupted) argument parity, runs the mult handshake with
// a timeout, and returns one in-order response per operand pair.
module mult_issue_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        rst,
    mult_issue_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TMR_W = $clog2(TIMEOUT);

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        corrupt_a;
        logic        corrupt_b;
    } entry_t;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RDY} state_t;

    entry_t           mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    state_t           state;
    logic [TMR_W-1:0] timer;

    logic             push_c;
    logic             pop_c;
    logic             out_free_c;
    logic             timer_done_c;
    logic             cap_c;
    logic             tmo_c;
    logic [CNT_W-1:0] count_next_c;
    entry_t           head_c;

    // Handshake qualifiers, next FIFO occupancy and response-load conditions
    always_comb begin
        push_c       = bus.in_valid && bus.in_ready;
        out_free_c   = !bus.out_valid || bus.out_ready;
        pop_c        = (state == IDLE) && (count != '0) && out_free_c;
        count_next_c = count;
        if (push_c && !pop_c) begin
            count_next_c = count + CNT_W'(1);
        end else if (pop_c && !push_c) begin
            count_next_c = count - CNT_W'(1);
        end
        timer_done_c = (timer == TMR_W'(TIMEOUT - 1));
        head_c       = mem[rd_ptr];
        cap_c        = ((state == REQ) && bus.ack && bus.result_rdy) ||
                       ((state == WAIT_RDY) && bus.result_rdy);
        tmo_c        = (((state == REQ) && !bus.ack) ||
                        ((state == WAIT_RDY) && !bus.result_rdy)) && timer_done_c;
    end

    // Entry storage; data needs no reset since occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= entry_t'{a: bus.in_arg_a, b: bus.in_arg_b,
                                    corrupt_a: bus.in_corrupt_a,
                                    corrupt_b: bus.in_corrupt_b};
        end
    end

    // FIFO pointers, occupancy and registered not-full flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            bus.in_ready <= 1'b1;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count        <= count_next_c;
            bus.in_ready <= (count_next_c != CNT_W'(FIFO_DEPTH));
        end
    end

    assign bus.fifo_count = count;

    // Issue FSM, operand registers toward mult and response register
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            timer             <= '0;
            bus.req           <= 1'b0;
            bus.arg_a         <= '0;
            bus.arg_b         <= '0;
            bus.arg_a_parity  <= 1'b0;
            bus.arg_b_parity  <= 1'b0;
            bus.out_valid     <= 1'b0;
            bus.out_result    <= '0;
            bus.out_parity_ok <= 1'b0;
            bus.out_arg_err   <= 1'b0;
            bus.out_timeout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop_c) begin
                        bus.arg_a        <= head_c.a;
                        bus.arg_b        <= head_c.b;
                        bus.arg_a_parity <= (^head_c.a) ^ head_c.corrupt_a;
                        bus.arg_b_parity <= (^head_c.b) ^ head_c.corrupt_b;
                        bus.req          <= 1'b1;
                        timer            <= '0;
                        state            <= REQ;
                    end
                end
                REQ: begin
                    if (bus.ack) begin
                        bus.req <= 1'b0;
                        timer   <= '0;
                        state   <= bus.result_rdy ? IDLE : WAIT_RDY;
                    end else if (timer_done_c) begin
                        bus.req <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                WAIT_RDY: begin
                    if (bus.result_rdy || timer_done_c) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            // A new response only loads when the register is free, so it never
            // overwrites an unconsumed one.
            if (cap_c) begin
                bus.out_valid     <= 1'b1;
                bus.out_result    <= bus.result;
                bus.out_parity_ok <= ((^bus.result) == bus.result_parity);
                bus.out_arg_err   <= bus.arg_parity_error;
                bus.out_timeout   <= 1'b0;
            end else if (tmo_c) begin
                bus.out_valid     <= 1'b1;
                bus.out_result    <= '0;
                bus.out_parity_ok <= 1'b0;
                bus.out_arg_err   <= 1'b0;
                bus.out_timeout   <= 1'b1;
            end else if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Self-checking bench for mult_issue_ctrl: directed operand pairs, a scripted
// mult model, and an in-order scoreboard checked every cycle.
module tb_mult_issue_ctrl;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned TIMEOUT    = 64;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        ca;
        logic        cb;
    } op_t;

    // Scripted mult behaviour for one issued op; ack_dly < 0 means never ack.
    typedef struct {
        int          ack_dly;
        int          rdy_dly;
        logic [31:0] res;
        logic        rpar;
        logic        aerr;
    } mode_t;

    logic clk;
    logic rst;

    mult_issue_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

    mult_issue_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_resp   = 0;
    int          op_idx   = 0;
    int          issue_k  = 0;
    bit          chk_en   = 0;
    mode_t       modes [64];
    op_t         op_q [$];
    logic [34:0] resp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input int idx, input int ack_dly, input int rdy_dly,
                            input logic [31:0] res, input logic flip, input logic aerr);
        modes[idx] = '{ack_dly, rdy_dly, res, (^res) ^ flip, aerr};
    endtask

    task automatic push_op(input logic [15:0] a, input logic [15:0] b,
                           input logic ca, input logic cb);
        int n = 0;
        bus.in_valid     = 1'b1;
        bus.in_arg_a     = a;
        bus.in_arg_b     = b;
        bus.in_corrupt_a = ca;
        bus.in_corrupt_b = cb;
        while (!bus.in_ready && n < 300) begin
            step();
            n++;
        end
        if (!bus.in_ready) check("push_accepted", 64'(bus.in_ready), 64'(1));
        else op_idx++;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_req(input string name, input int max);
        int n = 0;
        while (!bus.req && n < max) begin
            step();
            n++;
        end
        if (!bus.req) check({name, "_req_seen"}, 64'(bus.req), 64'(1));
    endtask

    task automatic wait_out_valid(input string name, input int max);
        int n = 0;
        while (!bus.out_valid && n < max) begin
            step();
            n++;
        end
        if (!bus.out_valid) check({name, "_out_valid_seen"}, 64'(bus.out_valid), 64'(1));
    endtask

    // Scripted mult: reacts to each new req according to modes[] in issue order
    initial begin : mult_model
        mode_t m;
        int    k;
        int    n;
        k = 0;
        bus.ack              = 1'b0;
        bus.result_rdy       = 1'b0;
        bus.result           = '0;
        bus.result_parity    = 1'b0;
        bus.arg_parity_error = 1'b0;
        forever begin
            step();
            if (bus.req && !rst) begin
                m = modes[k];
                k++;
                if (m.ack_dly < 0) begin
                    n = 0;
                    while (bus.req && n < 200) begin
                        step();
                        n++;
                    end
                end else begin
                    repeat (m.ack_dly) step();
                    bus.ack = 1'b1;
                    if (m.rdy_dly == 0) begin
                        bus.result_rdy       = 1'b1;
                        bus.result           = m.res;
                        bus.result_parity    = m.rpar;
                        bus.arg_parity_error = m.aerr;
                    end
                    step();
                    bus.ack        = 1'b0;
                    bus.result_rdy = 1'b0;
                    if (m.rdy_dly > 0) begin
                        repeat (m.rdy_dly - 1) step();
                        bus.result_rdy       = 1'b1;
                        bus.result           = m.res;
                        bus.result_parity    = m.rpar;
                        bus.arg_parity_error = m.aerr;
                        step();
                        bus.result_rdy = 1'b0;
                    end
                end
            end
        end
    end

    // Scoreboard: push-order queue of operands and expected responses
    logic        req_prev = 1'b0;
    logic [33:0] held_args;
    int          req_run  = 0;
    bit          cur_never = 0;

    always @(negedge clk) begin : scoreboard
        op_t         op;
        mode_t       m;
        logic [34:0] er;
        if (chk_en) begin
            if (bus.req && !req_prev) begin
                if (op_q.size() == 0) begin
                    check("req_without_entry", 64'(bus.req), 64'(0));
                end else begin
                    op = op_q.pop_front();
                    check("issue_args",
                          64'({bus.arg_a, bus.arg_b, bus.arg_a_parity, bus.arg_b_parity}),
                          64'({op.a, op.b, (^op.a) ^ op.ca, (^op.b) ^ op.cb}));
                    m = modes[issue_k];
                    issue_k++;
                    cur_never = (m.ack_dly < 0);
                    if (cur_never) er = {32'h0, 1'b0, 1'b0, 1'b1};
                    else er = {m.res, ((^m.res) == m.rpar), m.aerr, 1'b0};
                    resp_q.push_back(er);
                    held_args = {op.a, op.b, (^op.a) ^ op.ca, (^op.b) ^ op.cb};
                end
                req_run = 0;
            end
            if (bus.req) begin
                req_run++;
                check("args_stable",
                      64'({bus.arg_a, bus.arg_b, bus.arg_a_parity, bus.arg_b_parity}),
                      64'(held_args));
            end
            if (!bus.req && req_prev && cur_never) begin
                check("timeout_req_cycles", 64'(req_run), 64'(TIMEOUT));
                cur_never = 0;
            end
            if (resp_q.size() == 0) begin
                check("no_response_pending", 64'(bus.out_valid), 64'(0));
            end else if (bus.out_valid) begin
                check("response",
                      64'({bus.out_result, bus.out_parity_ok, bus.out_arg_err, bus.out_timeout}),
                      64'(resp_q[0]));
                if (bus.out_ready) begin
                    void'(resp_q.pop_front());
                    n_resp++;
                end
            end
            check("fifo_count", 64'(bus.fifo_count), 64'(op_q.size()));
            check("in_ready", 64'(bus.in_ready), 64'(op_q.size() < FIFO_DEPTH));
            if (rst) begin
                op_q.delete();
                resp_q.delete();
                cur_never = 0;
            end else if (bus.in_valid && bus.in_ready) begin
                op_q.push_back(op_t'{bus.in_arg_a, bus.in_arg_b, bus.in_corrupt_a, bus.in_corrupt_b});
            end
        end
        req_prev = bus.req;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Directed test sequence
    initial begin : main
        int acc;
        int n0;
        int n;
        int bad;
        rst              = 1'b1;
        bus.in_valid     = 1'b0;
        bus.in_arg_a     = '0;
        bus.in_arg_b     = '0;
        bus.in_corrupt_a = 1'b0;
        bus.in_corrupt_b = 1'b0;
        bus.out_ready    = 1'b1;
        for (int i = 0; i < 64; i++) set_mode(i, 0, 1, 32'h0, 1'b0, 1'b0);
        step();
        step();

        // reset values
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
        check("rst_mult_side",
              64'({bus.req, bus.arg_a, bus.arg_b, bus.arg_a_parity, bus.arg_b_parity}), 64'(0));
        check("rst_resp_side",
              64'({bus.out_valid, bus.out_result, bus.out_parity_ok, bus.out_arg_err,
                   bus.out_timeout, bus.fifo_count}), 64'(0));
        rst = 1'b0;
        step();
        chk_en = 1;

        // 1: basic product, latency push->req and result_rdy->out_valid
        set_mode(op_idx, 2, 1, 32'hFFFF_FFFA, 1'b0, 1'b0);
        push_op(16'h0003, 16'hFFFE, 1'b0, 1'b0);
        check("t1_req_not_yet", 64'(bus.req), 64'(0));
        step();
        check("t1_req_after_2", 64'(bus.req), 64'(1));
        check("t1_arg_parity", 64'({bus.arg_a_parity, bus.arg_b_parity}), 64'(2'b01));
        repeat (3) step();
        check("t1_out_valid_early", 64'(bus.out_valid), 64'(0));
        step();
        check("t1_resp",
              64'({bus.out_valid, bus.out_result, bus.out_parity_ok, bus.out_arg_err, bus.out_timeout}),
              64'({1'b1, 32'hFFFF_FFFA, 1'b1, 1'b0, 1'b0}));

        // 2: corrupted A parity, mult flags operand parity error
        set_mode(op_idx, 1, 2, 32'h0000_0005, 1'b0, 1'b1);
        push_op(16'h0001, 16'h0005, 1'b1, 1'b0);
        wait_req("t2", 20);
        check("t2_arg_a_parity", 64'(bus.arg_a_parity), 64'(0));
        wait_out_valid("t2", 20);
        check("t2_resp_flags", 64'({bus.out_arg_err, bus.out_timeout}), 64'(2'b10));
        step();

        // 3: back-pressure fills out register plus FIFO, then drains in order
        bus.out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            set_mode(op_idx, 0, 0, 32'h0000_0100 + 32'(i), 1'b0, (i == 2));
            bus.in_valid     = 1'b1;
            bus.in_arg_a     = 16'h0010 + 16'(i);
            bus.in_arg_b     = 16'h8000 | 16'(i);
            bus.in_corrupt_a = 1'b0;
            bus.in_corrupt_b = (i == 3);
            if (bus.in_ready) begin
                acc++;
                op_idx++;
            end
            step();
        end
        bus.in_valid = 1'b0;
        check("t3_accepted", 64'(acc), 64'(5));
        check("t3_full", 64'({bus.in_ready, bus.fifo_count, bus.out_valid}), 64'({1'b0, 3'd4, 1'b1}));
        n0 = n_resp;
        bus.out_ready = 1'b1;
        n = 0;
        while ((n_resp - n0) < 5 && n < 200) begin
            step();
            n++;
        end
        check("t3_drained_responses", 64'(n_resp - n0), 64'(5));
        check("t3_fifo_empty", 64'(bus.fifo_count), 64'(0));
        step();

        // 4: mult never acks -> timeout response, next entry issues normally
        set_mode(op_idx, -1, 0, 32'h0, 1'b0, 1'b0);
        push_op(16'h1234, 16'h5678, 1'b0, 1'b0);
        set_mode(op_idx, 1, 1, 32'h0000_0042, 1'b0, 1'b0);
        push_op(16'h0006, 16'h000B, 1'b0, 1'b0);
        wait_out_valid("t4_tmo", 200);
        check("t4_tmo_resp", 64'({bus.out_result, bus.out_timeout}), 64'({32'h0, 1'b1}));
        step();
        wait_out_valid("t4_next", 100);
        check("t4_next_resp", 64'({bus.out_result, bus.out_timeout}), 64'({32'h0000_0042, 1'b0}));
        step();

        // 5: ack and result_rdy in the same cycle, bad result parity
        set_mode(op_idx, 1, 0, 32'h0000_0001, 1'b1, 1'b0);
        push_op(16'h0001, 16'h0001, 1'b0, 1'b0);
        wait_req("t5", 20);
        step();
        check("t5_ack_cycle", 64'({bus.req, bus.out_valid}), 64'(2'b10));
        step();
        check("t5_resp", 64'({bus.out_valid, bus.out_parity_ok, bus.out_timeout, bus.req}), 64'(4'b1000));
        n0 = n_resp;
        repeat (5) step();
        check("t5_one_response", 64'(n_resp - n0), 64'(1));

        // 6: reset while waiting for result with two entries queued
        set_mode(op_idx, 0, 20, 32'h0000_0077, 1'b0, 1'b0);
        push_op(16'h0007, 16'h0011, 1'b0, 1'b0);
        wait_req("t6", 20);
        step();
        push_op(16'h0002, 16'h0003, 1'b0, 1'b0);
        push_op(16'h0004, 16'h0005, 1'b0, 1'b0);
        check("t6_queued", 64'(bus.fifo_count), 64'(2));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_after_rst",
              64'({bus.req, bus.out_valid, bus.fifo_count, bus.in_ready}),
              64'({1'b0, 1'b0, 3'd0, 1'b1}));
        bad = 0;
        repeat (30) begin
            step();
            if (bus.out_valid || bus.req) bad++;
        end
        check("t6_late_rdy_ignored", 64'(bad), 64'(0));

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
